modexp_ctrl: RTL and testbench

MODEXP_CTRL -- requirements
Module: modexp_ctrl

---
 rtl/modexp_ctrl_if.sv | 33 +++
 rtl/modexp_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_modexp_ctrl.sv | 510 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/modexp_ctrl_if.sv
// rtl/modexp_ctrl_if.sv - request, multiplier and result signals of modexp_ctrl
interface modexp_ctrl_if;
   // exponentiation request
   logic          start;
   logic [1023:0] in_x;
   logic [1023:0] in_r;
   logic [1023:0] in_e;
   logic [10:0]   in_t;
   logic [1023:0] in_m;
   // Montgomery multiplier request / response
   logic          mont_start;
   logic [1023:0] mont_a;
   logic [1023:0] mont_b;
   logic [1023:0] mont_m;
   logic [1023:0] mont_result;
   logic          mont_done;
   // exponentiation result
   logic [1023:0] result;
   logic          done;
   logic          busy;

   // controller side
   modport slave (
      input  start, in_x, in_r, in_e, in_t, in_m, mont_result, mont_done,
      output mont_start, mont_a, mont_b, mont_m, result, done, busy
   );

   // requester / multiplier side
   modport master (
      output start, in_x, in_r, in_e, in_t, in_m, mont_result, mont_done,
      input  mont_start, mont_a, mont_b, mont_m, result, done, busy
   );
endinterface

// File: rtl/modexp_ctrl.sv
// rtl/modexp_ctrl.sv - left-to-right square-and-multiply controller over a Montgomery multiplier (MODEXP_FROMMONT_EN adds final conversion)
module modexp_ctrl (
   input  logic         clk,
   input  logic         resetn,
   modexp_ctrl_if.slave bus
);
   localparam int W = 1024;

   typedef enum logic [3:0] {
      S_IDLE,
      S_LOAD,
      S_SQ_START,
      S_SQ_WAIT,
      S_MUL_START,
      S_MUL_WAIT,
`ifdef MODEXP_FROMMONT_EN
      S_CONV_START,
      S_CONV_WAIT,
`endif
      S_DONE
   } state_t;

   state_t         r_state;
   logic [W-1:0]   r_x;
   logic [W-1:0]   r_r;
   logic [W-1:0]   r_e;
   logic [W-1:0]   r_m;
   logic [10:0]    r_t;
   logic [W-1:0]   r_a;
   logic [9:0]     r_i;
   logic           r_mont_start;
   logic [W-1:0]   r_mont_a;
   logic [W-1:0]   r_mont_b;
   logic           r_done;
   logic           r_busy;
   logic [W-1:0]   r_result;

   logic [10:0]    w_t_clamp;
   logic           w_e_bit;
   logic           w_in_wait;
   logic           w_capture;
   logic           w_bit_end;
   logic           w_t_zero;
   logic           w_go_sq;
   logic           w_go_finish;
   logic [W-1:0]   w_a_next;

   // Exponent lengths beyond the operand width collapse to the full width
   assign w_t_clamp = (bus.in_t > 11'd1024) ? 11'd1024 : bus.in_t;
   assign w_e_bit   = r_e[r_i];
   assign w_t_zero  = (r_t == 11'd0);

`ifdef MODEXP_FROMMONT_EN
   assign w_in_wait = (r_state == S_SQ_WAIT) || (r_state == S_MUL_WAIT) || (r_state == S_CONV_WAIT);
`else
   assign w_in_wait = (r_state == S_SQ_WAIT) || (r_state == S_MUL_WAIT);
`endif

   // Multiplier responses only count while a product is outstanding
   assign w_capture = w_in_wait && bus.mont_done;

   // Accumulator value after this cycle: R on LOAD, the product on a response
   assign w_a_next  = (r_state == S_LOAD) ? r_r : (w_capture ? bus.mont_result : r_a);

   // End of one exponent bit: square done with e[i]=0, or multiply done
   assign w_bit_end = bus.mont_done &&
                      (((r_state == S_SQ_WAIT) && !w_e_bit) || (r_state == S_MUL_WAIT));

   // Shared exits of LOAD and of the bit-end step
   assign w_go_sq     = ((r_state == S_LOAD) && !w_t_zero) || (w_bit_end && (r_i != 10'd0));
   assign w_go_finish = ((r_state == S_LOAD) &&  w_t_zero) || (w_bit_end && (r_i == 10'd0));

   assign bus.mont_start = r_mont_start;
   assign bus.mont_a     = r_mont_a;
   assign bus.mont_b     = r_mont_b;
   assign bus.mont_m     = r_m;
   assign bus.result     = r_result;
   assign bus.done       = r_done;
   assign bus.busy       = r_busy;

   // Control FSM; mont_start and done are one-cycle pulses raised on entry to their states
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state      <= S_IDLE;
         r_x          <= '0;
         r_r          <= '0;
         r_e          <= '0;
         r_m          <= '0;
         r_t          <= '0;
         r_a          <= '0;
         r_i          <= '0;
         r_mont_start <= 1'b0;
         r_mont_a     <= '0;
         r_mont_b     <= '0;
         r_done       <= 1'b0;
         r_busy       <= 1'b0;
         r_result     <= '0;
      end else begin
         r_mont_start <= 1'b0;
         r_done       <= 1'b0;

         if ((r_state == S_LOAD) || w_capture) begin
            r_a <= w_a_next;
         end

         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  r_x     <= bus.in_x;
                  r_r     <= bus.in_r;
                  r_e     <= bus.in_e;
                  r_t     <= w_t_clamp;
                  r_m     <= bus.in_m;
                  r_busy  <= 1'b1;
                  r_state <= S_LOAD;
               end
            end
            S_LOAD: begin
               // t=1024 gives t[9:0]=0, which wraps to the correct top index 1023
               r_i <= w_t_zero ? 10'd0 : (r_t[9:0] - 10'd1);
            end
            S_SQ_START: begin
               r_state <= S_SQ_WAIT;
            end
            S_SQ_WAIT: begin
               if (bus.mont_done && w_e_bit) begin
                  r_mont_start <= 1'b1;
                  r_mont_a     <= w_a_next;
                  r_mont_b     <= r_x;
                  r_state      <= S_MUL_START;
               end
            end
            S_MUL_START: begin
               r_state <= S_MUL_WAIT;
            end
            S_MUL_WAIT: begin
            end
`ifdef MODEXP_FROMMONT_EN
            S_CONV_START: begin
               r_state <= S_CONV_WAIT;
            end
            S_CONV_WAIT: begin
               if (bus.mont_done) begin
                  r_result <= w_a_next;
                  r_done   <= 1'b1;
                  r_state  <= S_DONE;
               end
            end
`endif
            S_DONE: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase

         if (w_go_sq) begin
            r_mont_start <= 1'b1;
            r_mont_a     <= w_a_next;
            r_mont_b     <= w_a_next;
            r_state      <= S_SQ_START;
            if (w_bit_end) begin
               r_i <= r_i - 10'd1;
            end
         end

         if (w_go_finish) begin
`ifdef MODEXP_FROMMONT_EN
            // Leave the Montgomery domain: A * 1 * R^-1
            r_mont_start <= 1'b1;
            r_mont_a     <= w_a_next;
            r_mont_b     <= {{(W-1){1'b0}}, 1'b1};
            r_state      <= S_CONV_START;
`else
            r_result     <= w_a_next;
            r_done       <= 1'b1;
            r_state      <= S_DONE;
`endif
         end
      end
   end
endmodule

// File: tb/tb_modexp_ctrl.sv
// tb/tb_modexp_ctrl.sv - scoreboard bench for modexp_ctrl with a behavioural Montgomery core
module tb_modexp_ctrl;
   localparam int W      = 1024;
   localparam int K_SQ   = 0;
   localparam int K_MUL  = 1;
   localparam int K_CONV = 2;
`ifdef MODEXP_FROMMONT_EN
   localparam int CONV_OPS = 1;
`else
   localparam int CONV_OPS = 0;
`endif

   logic clk    = 1'b0;
   logic resetn = 1'b0;
   always #5 clk = ~clk;

   modexp_ctrl_if u_if ();

   modexp_ctrl dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (u_if)
   );

   int checks = 0;
   int errors = 0;

   int           exp_kind_q[$];
   logic [W-1:0] exp_res_q[$];

   logic [W-1:0] cur_x;
   logic [W-1:0] cur_r;
   logic [W-1:0] cur_m;
   logic [W-1:0] exp_a;
   logic [W-1:0] last_res;

   int pulse_cnt     = 0;
   int done_cnt      = 0;
   int core_done_cnt = 0;
   int busy_low_cnt  = 0;
   bit run_active    = 1'b0;
   int epoch         = 0;

   int           core_lat   = 1;
   int           core_cnt   = 0;
   int           core_epoch = 0;
   logic [W-1:0] core_a;
   logic [W-1:0] core_b;
   logic [W-1:0] core_res;
   int           inj_req = 0;
   int           inj_ack = 0;
   int           done_wait = 0;

   // Bit-serial Montgomery product a*b*2^-1024 mod m (a, b < m, m odd)
   function automatic logic [W-1:0] mont(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [W-1:0] m);
      logic [W+1:0] t;
      t = '0;
      for (int k = 0; k < W; k++) begin
         if (a[k]) t = t + {2'b00, b};
         if (t[0]) t = t + {2'b00, m};
         t = t >> 1;
      end
      if (t >= {2'b00, m}) t = t - {2'b00, m};
      return t[W-1:0];
   endfunction

   function automatic logic [W-1:0] mulmod(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [W-1:0] m);
      logic [2*W-1:0] p;
      p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
      p = p % {{W{1'b0}}, m};
      return p[W-1:0];
   endfunction

   function automatic logic [W-1:0] to_mont(input logic [W-1:0] y, input logic [W-1:0] m);
      logic [2*W-1:0] p;
      p = {y, {W{1'b0}}};
      p = p % {{W{1'b0}}, m};
      return p[W-1:0];
   endfunction

   // Plain (non-Montgomery) x^e mod m over the low t exponent bits
   function automatic logic [W-1:0] ref_pow(input logic [W-1:0] x, input logic [W-1:0] e,
                                            input int t, input logic [W-1:0] m);
      logic [W-1:0] acc;
      acc = 1;
      for (int k = t - 1; k >= 0; k--) begin
         acc = mulmod(acc, acc, m);
         if (e[k]) acc = mulmod(acc, x, m);
      end
      return acc;
   endfunction

   function automatic logic [W-1:0] rand_word();
      logic [W-1:0] v;
      for (int k = 0; k < W / 32; k++) v[32*k +: 32] = $urandom;
      return v;
   endfunction

   task automatic new_modulus();
      cur_m        = rand_word();
      cur_m[W-1]   = 1'b1;
      cur_m[0]     = 1'b1;
   endtask

   // Scoreboard monitor plus behavioural multiplier, both evaluated mid-cycle
   initial begin
      int           kind;
      logic [W-1:0] eb;
      logic [W-1:0] got;
      u_if.mont_done   = 1'b0;
      u_if.mont_result = '0;
      forever begin
         @(negedge clk);
         if (run_active && !u_if.busy) busy_low_cnt++;
         if (u_if.mont_start) begin
            pulse_cnt++;
            checks++;
            if (exp_kind_q.size() == 0) begin
               errors++;
               $display("FAIL op_unexpected: mont_start pulse %0d, required none", pulse_cnt);
            end else begin
               kind = exp_kind_q.pop_front();
               eb   = (kind == K_SQ) ? exp_a : ((kind == K_MUL) ? cur_x : {{(W-1){1'b0}}, 1'b1});
               if (u_if.mont_a !== exp_a || u_if.mont_b !== eb || u_if.mont_m !== cur_m) begin
                  errors++;
                  $display("FAIL op_operands: pulse %0d kind %0d got a=%h b=%h m=%h required a=%h b=%h m=%h",
                           pulse_cnt, kind, u_if.mont_a[63:0], u_if.mont_b[63:0], u_if.mont_m[63:0],
                           exp_a[63:0], eb[63:0], cur_m[63:0]);
               end
            end
         end
         if (u_if.done) begin
            done_cnt++;
            run_active = 1'b0;
            checks++;
            got = u_if.result;
            if (exp_res_q.size() == 0) begin
               errors++;
               $display("FAIL done_unexpected: done with result %h, required no done", got[63:0]);
            end else begin
               last_res = exp_res_q.pop_front();
               if (got !== last_res) begin
                  errors++;
                  $display("FAIL result: got %h required %h", got[63:0], last_res[63:0]);
               end
            end
         end
         u_if.mont_done = 1'b0;
         if (core_cnt > 0) begin
            core_cnt--;
            if (core_cnt == 0) begin
               if (core_epoch == epoch) begin
                  checks++;
                  if (u_if.mont_a !== core_a || u_if.mont_b !== core_b) begin
                     errors++;
                     $display("FAIL operand_stable: a=%h b=%h required a=%h b=%h",
                              u_if.mont_a[63:0], u_if.mont_b[63:0], core_a[63:0], core_b[63:0]);
                  end
               end
               u_if.mont_done   = 1'b1;
               u_if.mont_result = core_res;
               core_done_cnt++;
            end
         end
         if (inj_req != inj_ack) begin
            inj_ack          = inj_req;
            u_if.mont_done   = 1'b1;
            u_if.mont_result = rand_word();
         end
         if (u_if.mont_start) begin
            core_a     = u_if.mont_a;
            core_b     = u_if.mont_b;
            core_res   = mont(u_if.mont_a, u_if.mont_b, u_if.mont_m);
            exp_a      = core_res;
            core_epoch = epoch;
            core_cnt   = core_lat;
         end
      end
   end

   // Drive one request, push its expected operation kinds and result, pulse start
   task automatic start_run(input logic [W-1:0] xn, input logic [W-1:0] e, input int t_in,
                            input int lat);
      int           tt;
      logic [W-1:0] y;
      tt       = (t_in > 1024) ? 1024 : t_in;
      cur_x    = to_mont(xn, cur_m);
      cur_r    = to_mont(1, cur_m);
      exp_a    = cur_r;
      core_lat = lat;
      for (int k = tt - 1; k >= 0; k--) begin
         exp_kind_q.push_back(K_SQ);
         if (e[k]) exp_kind_q.push_back(K_MUL);
      end
      y = ref_pow(xn, e, tt, cur_m);
`ifdef MODEXP_FROMMONT_EN
      exp_kind_q.push_back(K_CONV);
      exp_res_q.push_back(y);
`else
      exp_res_q.push_back(to_mont(y, cur_m));
`endif
      u_if.in_x = cur_x;
      u_if.in_r = cur_r;
      u_if.in_e = e;
      u_if.in_t = t_in[10:0];
      u_if.in_m = cur_m;
      @(posedge clk);
      #1 u_if.start = 1'b1;
      @(posedge clk);
      #1 u_if.start = 1'b0;
      run_active = 1'b1;
   endtask

   task automatic wait_done(input int budget, output bit ok);
      int d0;
      int k;
      d0 = done_cnt;
      k  = 0;
      while (done_cnt == d0 && k < budget) begin
         @(negedge clk);
         #1;
         k++;
      end
      ok        = (done_cnt != d0);
      done_wait = k;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++;
      if (u_if.done !== 1'b0 || u_if.busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_flags: done=%b busy=%b required 0 0", u_if.done, u_if.busy);
      end
      checks++;
      if (u_if.mont_start !== 1'b0) begin
         errors++;
         $display("FAIL reset_mont_start: got %b required 0", u_if.mont_start);
      end
      checks++;
      if (u_if.result !== '0 || u_if.mont_a !== '0 || u_if.mont_b !== '0 || u_if.mont_m !== '0) begin
         errors++;
         $display("FAIL reset_data: result=%h a=%h b=%h m=%h required 0",
                  u_if.result[63:0], u_if.mont_a[63:0], u_if.mont_b[63:0], u_if.mont_m[63:0]);
      end
      resetn = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (u_if.busy !== 1'b0 || pulse_cnt != 0) begin
         errors++;
         $display("FAIL idle_after_reset: busy=%b pulses=%0d required 0 0", u_if.busy, pulse_cnt);
      end
   endtask

   task automatic test_sq_mul_order();
      int p0;
      int d0;
      bit ok;
      new_modulus();
      p0 = pulse_cnt;
      d0 = done_cnt;
      start_run(rand_word() % cur_m, 1024'b101, 3, 1);
      wait_done(200, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL sq_mul_timeout: no done within budget, required done");
      end
      repeat (3) @(negedge clk);
      checks++;
      if (pulse_cnt - p0 != 5 + CONV_OPS || done_cnt - d0 != 1) begin
         errors++;
         $display("FAIL sq_mul_counts: pulses=%0d dones=%0d required %0d 1",
                  pulse_cnt - p0, done_cnt - d0, 5 + CONV_OPS);
      end
      checks++;
      if (exp_kind_q.size() != 0 || u_if.busy !== 1'b0) begin
         errors++;
         $display("FAIL sq_mul_drain: pending=%0d busy=%b required 0 0", exp_kind_q.size(), u_if.busy);
      end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] e1;
      logic [W-1:0] e2;
      int           p0;
      int           need;
      bit           ok;
      new_modulus();
      e1 = '0;
      e2 = '0;
      e1[15:0] = 16'(($urandom | 32'h8000));
      e2[39:0] = {8'hA5, 32'($urandom)};
      need = 16 + $countones(e1[15:0]) + 40 + $countones(e2[39:0]) + 2 * CONV_OPS;
      p0 = pulse_cnt;
      start_run(rand_word() % cur_m, e1, 16, 1);
      wait_done(400, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL b2b_first_timeout: no done, required done");
      end
      start_run(rand_word() % cur_m, e2, 40, 2);
      wait_done(800, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL b2b_second_timeout: no done, required done");
      end
      repeat (2) @(negedge clk);
      checks++;
      if (pulse_cnt - p0 != need || exp_kind_q.size() != 0) begin
         errors++;
         $display("FAIL b2b_counts: pulses=%0d pending=%0d required %0d 0",
                  pulse_cnt - p0, exp_kind_q.size(), need);
      end
   endtask

   task automatic test_t_zero();
      int p0;
      bit ok;
      new_modulus();
      p0 = pulse_cnt;
      start_run(rand_word() % cur_m, rand_word(), 0, 1);
      wait_done(20, ok);
      checks++;
      if (!ok || done_wait > 3 + 2 * CONV_OPS) begin
         errors++;
         $display("FAIL t_zero_latency: done after %0d cycles (seen=%0d), required <= %0d",
                  done_wait, ok, 3 + 2 * CONV_OPS);
      end
      repeat (2) @(negedge clk);
      checks++;
      if (pulse_cnt - p0 != CONV_OPS) begin
         errors++;
         $display("FAIL t_zero_pulses: got %0d required %0d", pulse_cnt - p0, CONV_OPS);
      end
`ifndef MODEXP_FROMMONT_EN
      checks++;
      if (u_if.result !== cur_r) begin
         errors++;
         $display("FAIL t_zero_result: got %h required in_r %h", u_if.result[63:0], cur_r[63:0]);
      end
`endif
   endtask

   task automatic test_full_exponent();
      int p0;
      bit ok;
      new_modulus();
      p0           = pulse_cnt;
      busy_low_cnt = 0;
      start_run(rand_word() % cur_m, {W{1'b1}}, 1024, 1);
      wait_done(10000, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL full_timeout: no done within 10000 cycles, required done");
      end
      checks++;
      if (pulse_cnt - p0 != 2048 + CONV_OPS) begin
         errors++;
         $display("FAIL full_ops: got %0d required %0d", pulse_cnt - p0, 2048 + CONV_OPS);
      end
      checks++;
      if (busy_low_cnt != 0) begin
         errors++;
         $display("FAIL full_busy: busy low for %0d cycles, required 0", busy_low_cnt);
      end
   endtask

   task automatic test_t_clamp();
      int           p0;
      logic [W-1:0] e;
      bit           ok;
      new_modulus();
      e  = 1;
      p0 = pulse_cnt;
      start_run(rand_word() % cur_m, e, 2000, 1);
      wait_done(6000, ok);
      checks++;
      if (!ok || pulse_cnt - p0 != 1025 + CONV_OPS) begin
         errors++;
         $display("FAIL t_clamp: done=%0d pulses=%0d required 1 %0d", ok, pulse_cnt - p0, 1025 + CONV_OPS);
      end
   endtask

   task automatic test_ignore();
      int           p0;
      int           d0;
      int           k;
      logic [W-1:0] held;
      bit           ok;
      new_modulus();
      p0 = pulse_cnt;
      start_run(rand_word() % cur_m, 1024'b101, 3, 5);
      k = 0;
      while (pulse_cnt == p0 && k < 20) begin
         @(negedge clk);
         #1;
         k++;
      end
      @(negedge clk);
      u_if.in_x  = rand_word() % cur_m;
      u_if.in_e  = rand_word();
      u_if.in_t  = 11'd7;
      u_if.start = 1'b1;
      @(negedge clk);
      u_if.start = 1'b0;
      wait_done(200, ok);
      checks++;
      if (!ok || pulse_cnt - p0 != 5 + CONV_OPS) begin
         errors++;
         $display("FAIL start_while_busy: done=%0d pulses=%0d required 1 %0d", ok, pulse_cnt - p0, 5 + CONV_OPS);
      end
      repeat (3) @(negedge clk);
      p0   = pulse_cnt;
      d0   = done_cnt;
      held = u_if.result;
      inj_req++;
      repeat (4) @(negedge clk);
      checks++;
      if (pulse_cnt != p0 || done_cnt != d0 || u_if.busy !== 1'b0 || u_if.result !== held) begin
         errors++;
         $display("FAIL done_while_idle: pulses=%0d dones=%0d busy=%b required %0d %0d 0",
                  pulse_cnt, done_cnt, u_if.busy, p0, d0);
      end
   endtask

   task automatic test_reset_mid();
      int           p0;
      int           cd0;
      int           k;
      logic [W-1:0] e;
      bit           ok;
      new_modulus();
      p0 = pulse_cnt;
      start_run(rand_word() % cur_m, 1024'b11, 2, 6);
      k = 0;
      while (pulse_cnt - p0 < 2 && k < 40) begin
         @(negedge clk);
         #1;
         k++;
      end
      @(negedge clk);
      cd0    = core_done_cnt;
      resetn = 1'b0;
      epoch++;
      #1;
      checks++;
      if (u_if.busy !== 1'b0 || u_if.done !== 1'b0 || u_if.mont_start !== 1'b0 ||
          u_if.result !== '0 || u_if.mont_a !== '0 || u_if.mont_b !== '0 || u_if.mont_m !== '0) begin
         errors++;
         $display("FAIL reset_mid_outputs: busy=%b done=%b ms=%b result=%h a=%h m=%h required all 0",
                  u_if.busy, u_if.done, u_if.mont_start, u_if.result[63:0], u_if.mont_a[63:0],
                  u_if.mont_m[63:0]);
      end
      exp_kind_q.delete();
      exp_res_q.delete();
      run_active = 1'b0;
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      p0 = pulse_cnt;
      k  = 0;
      while (core_done_cnt == cd0 && k < 20) begin
         @(negedge clk);
         #1;
         k++;
      end
      @(negedge clk);
      checks++;
      if (core_done_cnt == cd0 || u_if.busy !== 1'b0 || pulse_cnt != p0) begin
         errors++;
         $display("FAIL stale_done: stale_seen=%0d busy=%b pulses=%0d required 1 0 %0d",
                  core_done_cnt != cd0, u_if.busy, pulse_cnt, p0);
      end
      e = '0;
      e[7:0] = 8'(($urandom | 32'h80));
      start_run(rand_word() % cur_m, e, 8, 1);
      wait_done(200, ok);
      checks++;
      if (!ok || pulse_cnt - p0 != 8 + $countones(e[7:0]) + CONV_OPS) begin
         errors++;
         $display("FAIL reset_mid_rerun: done=%0d pulses=%0d required 1 %0d",
                  ok, pulse_cnt - p0, 8 + $countones(e[7:0]) + CONV_OPS);
      end
   endtask

   initial begin
      u_if.start = 1'b0;
      u_if.in_x  = '0;
      u_if.in_r  = '0;
      u_if.in_e  = '0;
      u_if.in_t  = '0;
      u_if.in_m  = '0;
      test_reset();
      test_sq_mul_order();
      test_back_to_back();
      test_t_zero();
      test_full_exponent();
      test_t_clamp();
      test_ignore();
      test_reset_mid();
      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
